// File: rtl/clkdiv_detect.sv
// clkdiv_detect: edge strobes and lock detection of a div2/3/4 clock sampled on clkin.
module clkdiv_detect #(
    parameter int LOCK_COUNT = 2
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       clkdiv_in,
    output logic       rise_stb,
    output logic       fall_stb,
    output logic [1:0] ratio,
    output logic       locked,
    output logic       err
);
    typedef enum logic [1:0] {HUNT, CHECK, LOCK} state_t;

    localparam logic [1:0] LC = 2'(LOCK_COUNT);

    state_t     r_state, w_state_n;
    logic       r_in_q, r_rise, r_fall, r_err, w_err_n;
    logic [2:0] r_cnt;
    logic [1:0] r_cand, w_cand_n, r_match, w_match_n, r_ratio, w_ratio_n;
    logic       w_rise, w_fall, w_valid;
    logic [1:0] w_code, w_inc;

    assign w_rise  = clkdiv_in & ~r_in_q;
    assign w_fall  = ~clkdiv_in & r_in_q;
    assign w_valid = (r_cnt == 3'd2) || (r_cnt == 3'd3) || (r_cnt == 3'd4);
    // periods 2,3,4 map onto ratio codes 01,10,11
    assign w_code  = r_cnt[1:0] - 2'd1;
    assign w_inc   = r_match + 2'd1;

    assign rise_stb = r_rise;
    assign fall_stb = r_fall;
    assign ratio    = r_ratio;
    assign locked   = (r_state == LOCK);
    assign err      = r_err;

    always_comb begin
        w_state_n = r_state;
        w_cand_n  = r_cand;
        w_match_n = r_match;
        w_ratio_n = r_ratio;
        w_err_n   = 1'b0;
        if (w_rise) begin
            case (r_state)
                HUNT: begin
                    w_state_n = CHECK;
                    w_cand_n  = 2'd0;
                    w_match_n = 2'd0;
                end
                CHECK: begin
                    w_cand_n  = w_valid ? w_code : 2'd0;
                    w_match_n = !w_valid ? 2'd0 : (w_code == r_cand) ? w_inc : 2'd1;
                    if (w_valid && w_match_n == LC) begin
                        w_state_n = LOCK;
                        w_ratio_n = w_code;
                    end
                end
                LOCK: begin
                    if (!w_valid || w_code != r_ratio) begin
                        w_err_n   = 1'b1;
                        w_state_n = CHECK;
                        w_ratio_n = 2'd0;
                        w_cand_n  = w_valid ? w_code : 2'd0;
                        w_match_n = w_valid ? 2'd1 : 2'd0;
                        if (w_valid && LC == 2'd1) begin
                            w_state_n = LOCK;
                            w_ratio_n = w_code;
                        end
                    end
                end
                default: w_state_n = HUNT;
            endcase
        end else if (r_cnt == 3'd7 && r_state != HUNT) begin
            w_err_n   = (r_state == LOCK);
            w_state_n = HUNT;
            w_cand_n  = 2'd0;
            w_match_n = 2'd0;
            w_ratio_n = 2'd0;
        end
    end

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            r_state <= HUNT;
            r_in_q  <= 1'b1;
            r_cnt   <= 3'd0;
            r_cand  <= 2'd0;
            r_match <= 2'd0;
            r_ratio <= 2'd0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_in_q  <= clkdiv_in;
            r_cnt   <= w_rise ? 3'd1 : (r_cnt == 3'd7) ? 3'd7 : r_cnt + 3'd1;
            r_cand  <= w_cand_n;
            r_match <= w_match_n;
            r_ratio <= w_ratio_n;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
            r_err   <= w_err_n;
        end
    end
endmodule
